// File: rtl/bypass_pkg.sv
// Shared types and sizes for the decode-side operand bypass controller.
package bypass_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NREG       = 32;

  typedef enum logic [1:0] {
    SEL_REG = 2'd0,
    SEL_E   = 2'd1,
    SEL_M   = 2'd2,
    SEL_W   = 2'd3
  } bypass_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } bypass_state_t;

endpackage

// File: rtl/operand_bypass_ctrl_if.sv
// Decode/forwarding bundle between the decode stage (master) and the bypass controller (slave).
interface operand_bypass_ctrl_if;
  import bypass_pkg::*;

  logic                  D_valid;
  logic [REG_ADDR_W-1:0] D_rs1_addr;
  logic [REG_ADDR_W-1:0] D_rs2_addr;
  logic                  D_rs1_used;
  logic                  D_rs2_used;
  logic                  D_is_load;
  logic [REG_ADDR_W-1:0] D_rd_addr;
  logic                  flush;
  logic [REG_ADDR_W-1:0] E_fwd_addr;
  logic [REG_ADDR_W-1:0] M_fwd_addr;
  logic [REG_ADDR_W-1:0] W_fwd_addr;
  logic                  W_load_wb;
  logic [REG_ADDR_W-1:0] W_load_rd;
  logic                  D_stall;
  logic                  DE_valid;
  bypass_sel_t           DE_rs1_sel;
  bypass_sel_t           DE_rs2_sel;
  logic                  err_stall_timeout;

  modport master (
    output D_valid, D_rs1_addr, D_rs2_addr, D_rs1_used, D_rs2_used, D_is_load, D_rd_addr,
           flush, E_fwd_addr, M_fwd_addr, W_fwd_addr, W_load_wb, W_load_rd,
    input  D_stall, DE_valid, DE_rs1_sel, DE_rs2_sel, err_stall_timeout
  );

  modport slave (
    input  D_valid, D_rs1_addr, D_rs2_addr, D_rs1_used, D_rs2_used, D_is_load, D_rd_addr,
           flush, E_fwd_addr, M_fwd_addr, W_fwd_addr, W_load_wb, W_load_rd,
    output D_stall, DE_valid, DE_rs1_sel, DE_rs2_sel, err_stall_timeout
  );

endinterface

// File: rtl/bypass_match.sv
// One-operand forward-source priority encoder (youngest stage wins).
// W-stage forwarding is enabled by defining FWD_W_STAGE_EN.
module bypass_match
  import bypass_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic                  used,
  input  logic [REG_ADDR_W-1:0] e_addr,
  input  logic [REG_ADDR_W-1:0] m_addr,
  input  logic [REG_ADDR_W-1:0] w_addr,
  output bypass_sel_t           sel_c
);

  // x0 never forwards; forward addrs of 0 mean "no writer" and thus cannot match
  logic live;
  assign live = used && (addr != '0);

`ifdef FWD_W_STAGE_EN
  always_comb begin
    sel_c = SEL_REG;
    if (live && (addr == e_addr))      sel_c = SEL_E;
    else if (live && (addr == m_addr)) sel_c = SEL_M;
    else if (live && (addr == w_addr)) sel_c = SEL_W;
  end
`else
  // Regfile write-through already covers a same-cycle W write
  always_comb begin
    sel_c = SEL_REG;
    if (live && (addr == e_addr))      sel_c = SEL_E;
    else if (live && (addr == m_addr)) sel_c = SEL_M;
  end

  logic unused_w;
  assign unused_w = ^w_addr;
`endif

endmodule

// File: rtl/operand_bypass_ctrl.sv
// Decode-side bypass/stall controller: load scoreboard, stall FSM with watchdog, D->E selects.
// Optional W-stage forwarding via FWD_W_STAGE_EN (see bypass_match).
module operand_bypass_ctrl
  import bypass_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rstd,
  operand_bypass_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT + 1);

  logic [NREG-1:0]  sb_q, sb_d;
  bypass_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             de_valid_q;
  bypass_sel_t      rs1_sel_q, rs2_sel_q;
  bypass_sel_t      rs1_sel_c, rs2_sel_c;
  logic             rs1_busy, rs2_busy, hazard, issue;

  bypass_match u_match_rs1 (
    .addr   (bus.D_rs1_addr),
    .used   (bus.D_rs1_used),
    .e_addr (bus.E_fwd_addr),
    .m_addr (bus.M_fwd_addr),
    .w_addr (bus.W_fwd_addr),
    .sel_c  (rs1_sel_c)
  );

  bypass_match u_match_rs2 (
    .addr   (bus.D_rs2_addr),
    .used   (bus.D_rs2_used),
    .e_addr (bus.E_fwd_addr),
    .m_addr (bus.M_fwd_addr),
    .w_addr (bus.W_fwd_addr),
    .sel_c  (rs2_sel_c)
  );

  // A bit being cleared this cycle is still read as busy; the clear lands next cycle
  always_comb begin
    rs1_busy = bus.D_rs1_used && (bus.D_rs1_addr != '0) && sb_q[bus.D_rs1_addr];
    rs2_busy = bus.D_rs2_used && (bus.D_rs2_addr != '0) && sb_q[bus.D_rs2_addr];
    hazard   = bus.D_valid && !bus.flush && (rs1_busy || rs2_busy);
    issue    = bus.D_valid && !bus.flush && !hazard;
  end

  // Load scoreboard update: clear on load writeback, then set on load issue (set wins)
  always_comb begin
    sb_d = sb_q;
    if (bus.W_load_wb) sb_d[bus.W_load_rd] = 1'b0;
    if (issue && bus.D_is_load && (bus.D_rd_addr != '0)) sb_d[bus.D_rd_addr] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Stall FSM and consecutive-stall watchdog
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (hazard) begin
          state_d = STALL;
          cnt_d   = CNT_W'(1);
        end
      end
      STALL: begin
        if (hazard) begin
          cnt_d = (cnt_q == CNT_W'(STALL_TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (cnt_d == CNT_W'(STALL_TIMEOUT)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      sb_q       <= '0;
      de_valid_q <= 1'b0;
      rs1_sel_q  <= SEL_REG;
      rs2_sel_q  <= SEL_REG;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      sb_q       <= sb_d;
      de_valid_q <= issue;
      rs1_sel_q  <= issue ? rs1_sel_c : SEL_REG;
      rs2_sel_q  <= issue ? rs2_sel_c : SEL_REG;
    end
  end

  assign bus.D_stall           = hazard;
  assign bus.DE_valid          = de_valid_q;
  assign bus.DE_rs1_sel        = rs1_sel_q;
  assign bus.DE_rs2_sel        = rs2_sel_q;
  assign bus.err_stall_timeout = err_q;

endmodule

// File: tb/tb_operand_bypass_ctrl.sv
// Directed bench for operand_bypass_ctrl; expected W-only select follows FWD_W_STAGE_EN.
module tb_operand_bypass_ctrl;
  import bypass_pkg::*;

  logic clk;
  logic rstd;
  int   vectors;
  int   miscompares;

`ifdef FWD_W_STAGE_EN
  localparam bypass_sel_t W_EXP = SEL_W;
`else
  localparam bypass_sel_t W_EXP = SEL_REG;
`endif

  operand_bypass_ctrl_if bus ();

  operand_bypass_ctrl #(.STALL_TIMEOUT(16)) dut (
    .clk  (clk),
    .rstd (rstd),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.D_valid    = 1'b0;
    bus.D_rs1_addr = '0;
    bus.D_rs2_addr = '0;
    bus.D_rs1_used = 1'b0;
    bus.D_rs2_used = 1'b0;
    bus.D_is_load  = 1'b0;
    bus.D_rd_addr  = '0;
    bus.flush      = 1'b0;
    bus.E_fwd_addr = '0;
    bus.M_fwd_addr = '0;
    bus.W_fwd_addr = '0;
    bus.W_load_wb  = 1'b0;
    bus.W_load_rd  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_load(input logic [4:0] rd);
    idle();
    bus.D_valid   = 1'b1;
    bus.D_is_load = 1'b1;
    bus.D_rd_addr = rd;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstd        = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_de_valid", 32'(bus.DE_valid), 32'd0);
    chk("rst_rs1_sel", 32'(bus.DE_rs1_sel), 32'(SEL_REG));
    chk("rst_rs2_sel", 32'(bus.DE_rs2_sel), 32'(SEL_REG));
    chk("rst_err", 32'(bus.err_stall_timeout), 32'd0);
    chk("rst_stall", 32'(bus.D_stall), 32'd0);
    rstd = 1'b1;
    tick();

    // ALU result in E forwards to rs1
    bus.D_valid = 1'b1; bus.D_rs1_addr = 5'd5; bus.D_rs1_used = 1'b1; bus.E_fwd_addr = 5'd5;
    #1 chk("t1_stall", 32'(bus.D_stall), 32'd0);
    tick();
    chk("t1_de_valid", 32'(bus.DE_valid), 32'd1);
    chk("t1_rs1_sel", 32'(bus.DE_rs1_sel), 32'(SEL_E));
    chk("t1_rs2_sel", 32'(bus.DE_rs2_sel), 32'(SEL_REG));

    // Priority E > M > W on rs2
    idle();
    bus.D_valid = 1'b1; bus.D_rs2_addr = 5'd7; bus.D_rs2_used = 1'b1;
    bus.E_fwd_addr = 5'd7; bus.M_fwd_addr = 5'd7; bus.W_fwd_addr = 5'd7;
    tick();
    chk("t2_e_wins", 32'(bus.DE_rs2_sel), 32'(SEL_E));
    bus.E_fwd_addr = 5'd0;
    tick();
    chk("t2_m_next", 32'(bus.DE_rs2_sel), 32'(SEL_M));
    bus.M_fwd_addr = 5'd0;
    tick();
    chk("t2_w_only", 32'(bus.DE_rs2_sel), 32'(W_EXP));
    bus.D_rs2_used = 1'b0; bus.E_fwd_addr = 5'd7;
    tick();
    chk("t2_unused", 32'(bus.DE_rs2_sel), 32'(SEL_REG));

    // x0 never forwards; load to x0 sets nothing
    idle();
    bus.D_valid = 1'b1; bus.D_rs1_used = 1'b1; bus.D_rs1_addr = 5'd0;
    tick();
    chk("t4_x0_sel", 32'(bus.DE_rs1_sel), 32'(SEL_REG));
    chk("t4_x0_valid", 32'(bus.DE_valid), 32'd1);
    issue_load(5'd0);
    idle();
    bus.D_valid = 1'b1; bus.D_rs1_used = 1'b1; bus.D_rs1_addr = 5'd0;
    #1 chk("t4_ld_x0_stall", 32'(bus.D_stall), 32'd0);

    // Load-use stall on x9 until the cycle after writeback
    issue_load(5'd9);
    chk("t3_ld_issue", 32'(bus.DE_valid), 32'd1);
    idle();
    bus.D_valid = 1'b1; bus.D_rs1_used = 1'b1; bus.D_rs1_addr = 5'd9;
    #1 chk("t3_stall0", 32'(bus.D_stall), 32'd1);
    tick();
    chk("t3_bubble0", 32'(bus.DE_valid), 32'd0);
    chk("t3_stall1", 32'(bus.D_stall), 32'd1);
    tick();
    chk("t3_bubble1", 32'(bus.DE_valid), 32'd0);
    bus.W_load_wb = 1'b1; bus.W_load_rd = 5'd9;
    #1 chk("t3_stall_on_clr", 32'(bus.D_stall), 32'd1);
    tick();
    chk("t3_bubble2", 32'(bus.DE_valid), 32'd0);
    bus.W_load_wb = 1'b0; bus.W_load_rd = 5'd0;
    #1 chk("t3_released", 32'(bus.D_stall), 32'd0);
    tick();
    chk("t3_issue", 32'(bus.DE_valid), 32'd1);
    chk("t3_sel_reg", 32'(bus.DE_rs1_sel), 32'(SEL_REG));

    // Same-register set and clear in one cycle: set wins
    idle();
    bus.D_valid = 1'b1; bus.D_is_load = 1'b1; bus.D_rd_addr = 5'd10;
    bus.W_load_wb = 1'b1; bus.W_load_rd = 5'd10;
    tick();
    idle();
    bus.D_valid = 1'b1; bus.D_rs2_used = 1'b1; bus.D_rs2_addr = 5'd10;
    #1 chk("set_wins_stall", 32'(bus.D_stall), 32'd1);
    bus.W_load_wb = 1'b1; bus.W_load_rd = 5'd10;
    tick();
    bus.W_load_wb = 1'b0;
    #1 chk("set_wins_clear", 32'(bus.D_stall), 32'd0);
    tick();

    // Flushed load does not mark the scoreboard
    idle();
    bus.D_valid = 1'b1; bus.D_is_load = 1'b1; bus.D_rd_addr = 5'd4; bus.flush = 1'b1;
    tick();
    chk("flush_ld_valid", 32'(bus.DE_valid), 32'd0);
    idle();
    bus.D_valid = 1'b1; bus.D_rs1_used = 1'b1; bus.D_rs1_addr = 5'd4;
    #1 chk("flush_ld_nostall", 32'(bus.D_stall), 32'd0);

    // Watchdog: 16 consecutive stall cycles
    issue_load(5'd12);
    idle();
    bus.D_valid = 1'b1; bus.D_rs1_used = 1'b1; bus.D_rs1_addr = 5'd12;
    repeat (8) tick();
    chk("t5_err_early", 32'(bus.err_stall_timeout), 32'd0);
    repeat (8) tick();
    chk("t5_err_set", 32'(bus.err_stall_timeout), 32'd1);
    bus.W_load_wb = 1'b1; bus.W_load_rd = 5'd12;
    tick();
    bus.W_load_wb = 1'b0;
    tick();
    chk("t5_after_valid", 32'(bus.DE_valid), 32'd1);
    chk("t5_err_sticky", 32'(bus.err_stall_timeout), 32'd1);

    // Flush overrides hazard, then reset mid-stall
    issue_load(5'd3);
    idle();
    bus.D_valid = 1'b1; bus.D_rs1_used = 1'b1; bus.D_rs1_addr = 5'd3; bus.flush = 1'b1;
    #1 chk("t6_flush_stall", 32'(bus.D_stall), 32'd0);
    tick();
    chk("t6_flush_valid", 32'(bus.DE_valid), 32'd0);
    bus.flush = 1'b0;
    #1 chk("t6_hazard_back", 32'(bus.D_stall), 32'd1);
    repeat (2) tick();
    rstd = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.DE_valid), 32'd0);
    chk("t6_rst_err", 32'(bus.err_stall_timeout), 32'd0);
    chk("t6_rst_sb", 32'(bus.D_stall), 32'd0);
    #1 rstd = 1'b1;
    tick();
    chk("t6_post_valid", 32'(bus.DE_valid), 32'd1);
    chk("t6_post_sel", 32'(bus.DE_rs1_sel), 32'(SEL_REG));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
